// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT command sequencer: ctrl set_state codes,
// error codes, field widths and the sequencer state encoding.
package ntt_pkg;

    localparam int OP_W   = 3;
    localparam int PMAX_W = 4;

    localparam logic [OP_W-1:0] ST_IDLE  = 3'b000;
    localparam logic [OP_W-1:0] ST_NTT   = 3'b001;
    localparam logic [OP_W-1:0] ST_PWM   = 3'b010;
    localparam logic [OP_W-1:0] ST_INTT  = 3'b011;
    localparam logic [OP_W-1:0] ST_SCALE = 3'b100;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL_OP = 2'b01;
    localparam logic [1:0] ERR_ACK_TMO    = 2'b10;
    localparam logic [1:0] ERR_RUN_TMO    = 2'b11;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_WAIT_ACK,
        SEQ_WAIT_DONE,
        SEQ_REPORT
    } seqState_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [PMAX_W-1:0] pmax;
    } cmd_t;

    // Only the four run states of ctrl may be requested by the host.
    function automatic logic isLegalOp(input logic [OP_W-1:0] op);
        return (op >= ST_NTT) && (op <= ST_SCALE);
    endfunction

endpackage

// File: rtl/ntt_cmd_seq_if.sv
// Host command bus for the NTT command sequencer (valid/ready handshake).
interface ntt_cmd_seq_if;
    import ntt_pkg::*;

    logic              cmd_valid;
    logic [OP_W-1:0]   cmd_op;
    logic [PMAX_W-1:0] cmd_pmax;
    logic              cmd_ready;

    modport master (output cmd_valid, output cmd_op, output cmd_pmax, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_pmax, output cmd_ready);

endinterface

// File: rtl/ntt_cmd_fifo.sv
// Small synchronous command FIFO (DEPTH entries of op+pmax) with async reset.
module ntt_cmd_fifo
    import ntt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  cmd_t pushData_i,
    input  logic pop_i,
    output cmd_t popData_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign doPush    = push_i && !full_o;
    assign doPop     = pop_i && !empty_o;
    assign popData_o = mem[rdPtr_q];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= pushData_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ntt_cmd_seq.sv
// Host-side command initiator for the NTT ctrl FSM: queues opcodes, issues them to
// ctrl, follows cur_state to completion and reports done/err per command.
module ntt_cmd_seq
    import ntt_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int START_HOLD = 3,
    parameter int ACK_TMO    = 16,
    parameter int RUN_TMO    = 4096
) (
    input  logic              clk,
    input  logic              rst,
    ntt_cmd_seq_if.slave      cmd,
    input  logic [OP_W-1:0]   ctrl_cur_state_i,
    output logic              ctrl_start_o,
    output logic [OP_W-1:0]   ctrl_set_state_o,
    output logic [PMAX_W-1:0] ctrl_p_max_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [OP_W-1:0]   done_op_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int ACK_W = $clog2(ACK_TMO + 1);
    localparam int RUN_W = $clog2(RUN_TMO + 1);

    seqState_e         state_q,   state_d;
    logic [OP_W-1:0]   curOp_q,   curOp_d;
    logic [PMAX_W-1:0] pMax_q,    pMax_d;
    logic [ACK_W-1:0]  ackCnt_q,  ackCnt_d;
    logic [RUN_W-1:0]  runCnt_q,  runCnt_d;
    logic              acked_q,   acked_d;
    logic [1:0]        errCode_q, errCode_d;

    logic fifoPop;
    logic fifoFull;
    logic fifoEmpty;
    cmd_t pushData;
    cmd_t head;
    logic curActive;

    assign pushData      = {cmd.cmd_op, cmd.cmd_pmax};
    assign cmd.cmd_ready = !fifoFull;

    ntt_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (cmd.cmd_valid),
        .pushData_i (pushData),
        .pop_i      (fifoPop),
        .popData_o  (head),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // The ack counter doubles as the start-hold timer: both start at the first ISSUE cycle.
    always_comb begin
        state_d   = state_q;
        curOp_d   = curOp_q;
        pMax_d    = pMax_q;
        ackCnt_d  = ackCnt_q;
        runCnt_d  = runCnt_q;
        acked_d   = acked_q;
        errCode_d = errCode_q;
        fifoPop   = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop  = 1'b1;
                    curOp_d  = head.op;
                    ackCnt_d = '0;
                    runCnt_d = '0;
                    acked_d  = 1'b0;
                    if (isLegalOp(head.op)) begin
                        pMax_d    = head.pmax;
                        errCode_d = ERR_NONE;
                        state_d   = SEQ_ISSUE;
                    end else begin
                        errCode_d = ERR_ILLEGAL_OP;
                        state_d   = SEQ_REPORT;
                    end
                end
            end

            SEQ_ISSUE: begin
                if (ackCnt_q != ACK_W'(ACK_TMO)) begin
                    ackCnt_d = ackCnt_q + 1'b1;
                end
                if (ctrl_cur_state_i != ST_IDLE) begin
                    acked_d = 1'b1;
                end
                if (ackCnt_q == ACK_W'(START_HOLD - 1)) begin
                    state_d = SEQ_WAIT_ACK;
                end
            end

            SEQ_WAIT_ACK: begin
                if (ackCnt_q != ACK_W'(ACK_TMO)) begin
                    ackCnt_d = ackCnt_q + 1'b1;
                end
                if (acked_q || (ctrl_cur_state_i != ST_IDLE)) begin
                    state_d = SEQ_WAIT_DONE;
                end else if (ackCnt_q == ACK_W'(ACK_TMO)) begin
                    errCode_d = ERR_ACK_TMO;
                    state_d   = SEQ_REPORT;
                end
            end

            SEQ_WAIT_DONE: begin
                if (runCnt_q != RUN_W'(RUN_TMO)) begin
                    runCnt_d = runCnt_q + 1'b1;
                end
                if (ctrl_cur_state_i == ST_IDLE) begin
                    state_d = SEQ_REPORT;
                end else if (runCnt_q == RUN_W'(RUN_TMO)) begin
                    errCode_d = ERR_RUN_TMO;
                    state_d   = SEQ_REPORT;
                end
            end

            SEQ_REPORT: begin
                state_d = SEQ_IDLE;
            end

            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEQ_IDLE;
            curOp_q   <= ST_IDLE;
            pMax_q    <= '0;
            ackCnt_q  <= '0;
            runCnt_q  <= '0;
            acked_q   <= 1'b0;
            errCode_q <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            curOp_q   <= curOp_d;
            pMax_q    <= pMax_d;
            ackCnt_q  <= ackCnt_d;
            runCnt_q  <= runCnt_d;
            acked_q   <= acked_d;
            errCode_q <= errCode_d;
        end
    end

    // Outputs decode straight from registers so reset clears them without waiting for a clock.
    assign curActive        = state_q inside {SEQ_ISSUE, SEQ_WAIT_ACK, SEQ_WAIT_DONE};
    assign ctrl_start_o     = (state_q == SEQ_ISSUE);
    assign ctrl_set_state_o = curActive ? curOp_q : ST_IDLE;
    assign ctrl_p_max_o     = pMax_q;
    assign busy_o           = (state_q != SEQ_IDLE) || !fifoEmpty;
    assign done_o           = (state_q == SEQ_REPORT) && (errCode_q == ERR_NONE);
    assign err_o            = (state_q == SEQ_REPORT) && (errCode_q != ERR_NONE);
    assign done_op_o        = (state_q == SEQ_REPORT) ? curOp_q : ST_IDLE;
    assign err_code_o       = err_o ? errCode_q : ERR_NONE;

endmodule
